eink_scan_ctrl: RTL and testbench

Parametrised e-ink panel scan-timing generator, successor to the fixed-geometry ED060SC7 controller. Drives source-driver (sph, le, cl, data) and gate-driver (spv, ckv, oe, gmode) timing for any panel geometry and bus width. Runs a host-specified number of frames (phases) per start, with an external pixel-fetch address/data interface and a frame-boundary abort. Sits between the waveform/LUT stage (supplies pix_data for addr and phase) and the panel pins.

---
 rtl/eink_scan_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_eink_scan_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eink_scan_ctrl.sv
// eink_scan_ctrl: e-ink panel scan-timing generator with parametrised
// geometry. Produces source-driver (sph/le/cl/data) and gate-driver
// (spv/ckv/oe/gmode) timing for a host-requested number of frames,
// fetching pixel words via addr/pix_data, with frame-boundary abort.
module eink_scan_ctrl #(
    parameter int H_ACTIVE = 200,
    parameter int H_BLANK  = 6,
    parameter int V_ACTIVE = 600,
    parameter int V_BLANK  = 13,
    parameter int CKV_LOW  = 150,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 17,
    parameter int PHASE_W  = 7,
    parameter int CL_DIV   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [PHASE_W-1:0] phase_count,
    input  logic               abort,
    output logic               ready,
    output logic               busy,
    output logic               frame_done,
    output logic [PHASE_W-1:0] phase,
    output logic [ADDR_W-1:0]  addr,
    input  logic [DATA_W-1:0]  pix_data,
    output logic               cl,
    output logic               sph,
    output logic               le,
    output logic               spv,
    output logic               ckv,
    output logic               oe,
    output logic               gmode,
    output logic [DATA_W-1:0]  data
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = 1 + V_ACTIVE + V_BLANK;
    localparam int S_W     = $clog2(H_TOTAL);
    localparam int G_W     = $clog2(V_TOTAL);
    localparam int D_W     = $clog2(CL_DIV);

    localparam logic [S_W-1:0]    S_LAST = S_W'(H_TOTAL - 1);
    localparam logic [S_W-1:0]    S_HA   = S_W'(H_ACTIVE);
    localparam logic [S_W-1:0]    S_LE   = S_W'(H_ACTIVE + 1);
    localparam logic [S_W-1:0]    S_CKV  = S_W'(CKV_LOW);
    localparam logic [G_W-1:0]    G_LAST = G_W'(V_TOTAL - 1);
    localparam logic [G_W-1:0]    G_VA   = G_W'(V_ACTIVE);
    localparam logic [D_W-1:0]    D_LAST = D_W'(CL_DIV - 1);
    localparam logic [D_W-1:0]    D_HALF = D_W'(CL_DIV / 2);
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(V_ACTIVE * H_ACTIVE - 1);
    localparam logic [PHASE_W-1:0] P_ONE = PHASE_W'(1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t state_q, state_d;

    logic [D_W-1:0]     div_q;
    logic [S_W-1:0]     s_q;
    logic [G_W-1:0]     g_q;
    logic [PHASE_W-1:0] pc_q;
    logic               abort_pend_q;

    logic tick;
    logic eof;
    logic last_frame;
    logic start_ok;
    logic finish;
    logic data_line;
    logic pix_tick;

    // Decode of the current scan position and sequencing conditions.
    // (s_q, g_q) is the position the next tick will present on the pins.
    // An abort arriving on the very clock of a frame boundary also ends
    // the sequence there.
    always_comb begin
        tick       = (state_q == SCAN) && (div_q == D_LAST);
        eof        = tick && (s_q == S_LAST) && (g_q == G_LAST);
        last_frame = (phase == (pc_q - P_ONE));
        start_ok   = (state_q == IDLE) && start && (phase_count != '0);
        finish     = eof && (last_frame || abort_pend_q || abort);
        data_line  = (g_q != '0) && (g_q <= G_VA);
        pix_tick   = data_line && (s_q < S_HA);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = SCAN;
            SCAN:    if (finish)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs, including the source clock from the divider.
    always_comb begin
        ready = (state_q == IDLE);
        busy  = (state_q == SCAN);
        oe    = (state_q == SCAN);
        gmode = (state_q == SCAN);
        cl    = (state_q == SCAN) && (div_q >= D_HALF);
    end

    // cl divider: free-runs in SCAN, held at zero in IDLE.
    always_ff @(posedge clk) begin
        if (rst || (state_q == IDLE)) begin
            div_q <= '0;
        end else if (div_q == D_LAST) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + D_W'(1);
        end
    end

    // Sequence bookkeeping: latched frame count, abort request, phase index.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= '0;
            abort_pend_q <= 1'b0;
            phase        <= '0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= eof;
            if (start_ok) begin
                pc_q         <= phase_count;
                abort_pend_q <= 1'b0;
                phase        <= '0;
            end else if (state_q == SCAN) begin
                if (abort) begin
                    abort_pend_q <= 1'b1;
                end
                if (finish) begin
                    abort_pend_q <= 1'b0;
                    phase        <= '0;
                end else if (eof) begin
                    phase <= phase + P_ONE;
                end
            end
        end
    end

    // Scan position counters, advanced once per tick.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            s_q <= '0;
            g_q <= '0;
        end else if (tick) begin
            if (finish || (s_q == S_LAST)) begin
                s_q <= '0;
                g_q <= (finish || (g_q == G_LAST)) ? '0 : g_q + G_W'(1);
            end else begin
                s_q <= s_q + S_W'(1);
            end
        end
    end

    // Panel pin registers: present the decoded position on each tick.
    // addr always holds the next pixel word to be latched, so pix_data
    // has at least one full tick to settle; it wraps to 0 after the last
    // word of the frame.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            sph  <= 1'b1;
            spv  <= 1'b1;
            ckv  <= 1'b0;
            le   <= 1'b0;
            data <= '0;
            addr <= '0;
        end else if (tick) begin
            if (finish) begin
                sph  <= 1'b1;
                spv  <= 1'b1;
                ckv  <= 1'b0;
                le   <= 1'b0;
                data <= '0;
                addr <= '0;
            end else begin
                spv  <= (g_q != '0);
                ckv  <= (s_q < S_CKV);
                sph  <= !pix_tick;
                le   <= data_line && (s_q == S_LE);
                data <= pix_tick ? pix_data : '0;
                if (pix_tick) begin
                    addr <= (addr == A_LAST) ? '0 : addr + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_eink_scan_ctrl.sv
// tb_eink_scan_ctrl: table-driven sequences plus randomized stimulus,
// every clock compared against a time-based reference model.
module tb_eink_scan_ctrl;

    localparam int HA  = 4;
    localparam int HB  = 4;
    localparam int VA  = 3;
    localparam int VB  = 2;
    localparam int CKV = 2;
    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int PW  = 7;
    localparam int CLD = 4;
    localparam int HT  = HA + HB;
    localparam int VT  = 1 + VA + VB;
    localparam int NT  = HT * VT;      // ticks per frame
    localparam int FCLK = NT * CLD;    // clocks per frame

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, abort;
    logic [PW-1:0] phase_count;
    logic [DW-1:0] pix_data;
    logic          ready, busy, frame_done;
    logic [PW-1:0] phase;
    logic [AW-1:0] addr;
    logic          cl, sph, le, spv, ckv, oe, gmode;
    logic [DW-1:0] data;

    logic [DW-1:0] mem [256];
    always_comb pix_data = mem[addr];

    eink_scan_ctrl #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
        .CKV_LOW(CKV), .DATA_W(DW), .ADDR_W(AW), .PHASE_W(PW), .CL_DIV(CLD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .phase_count(phase_count),
        .abort(abort), .ready(ready), .busy(busy), .frame_done(frame_done),
        .phase(phase), .addr(addr), .pix_data(pix_data), .cl(cl),
        .sph(sph), .le(le), .spv(spv), .ckv(ckv), .oe(oe), .gmode(gmode),
        .data(data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: time since the accepted start, in clocks
    bit m_scan = 0, m_fd = 0, m_pend = 0;
    int m_t = 0, m_pc = 0;

    int fd_cnt, busy_cnt, le_cnt, spv_lo_cnt, sph_lo_cnt, cl_hi_cnt;

    typedef struct {
        int pc;
        int abort_at;
        int frames;
        int busy_clks;
        int le_clks;
        int spv_lo_clks;
        int sph_lo_clks;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        m_fd = 0;
        if (rst) begin
            m_scan = 0; m_t = 0; m_pend = 0;
        end else if (!m_scan) begin
            if (start && phase_count != 0) begin
                m_scan = 1; m_t = 0; m_pc = int'(phase_count); m_pend = 0;
            end
        end else begin
            m_t++;
            if (abort) m_pend = 1;
            if (m_t % FCLK == 0) begin
                m_fd = 1;
                if ((m_t / FCLK) == m_pc || m_pend) begin
                    m_scan = 0; m_t = 0; m_pend = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        int k, q, s, g, nxt;
        bit dl;
        int e_cl = 0, e_phase = 0, e_sph = 1, e_spv = 1, e_ckv = 0;
        int e_le = 0, e_data = 0, e_addr = 0;
        if (m_scan) begin
            e_cl = ((m_t % CLD) >= CLD / 2) ? 1 : 0;
            k = m_t / CLD;
            e_phase = k / NT;
            if (k >= 1) begin
                q = (k - 1) % NT;
                g = q / HT;
                s = q % HT;
                dl = (g >= 1) && (g <= VA);
                e_spv = (g != 0) ? 1 : 0;
                e_ckv = (s < CKV) ? 1 : 0;
                e_sph = (dl && s < HA) ? 0 : 1;
                e_le  = (dl && s == HA + 1) ? 1 : 0;
                e_data = (dl && s < HA) ? int'(mem[(g - 1) * HA + s]) : 0;
                if (dl) begin
                    nxt = (s + 1 < HA) ? s + 1 : HA;
                    e_addr = ((g - 1) * HA + nxt) % (VA * HA);
                end
            end
        end
        chk("ready", int'(ready), m_scan ? 0 : 1);
        chk("busy", int'(busy), m_scan ? 1 : 0);
        chk("oe", int'(oe), m_scan ? 1 : 0);
        chk("gmode", int'(gmode), m_scan ? 1 : 0);
        chk("frame_done", int'(frame_done), int'(m_fd));
        chk("phase", int'(phase), e_phase);
        chk("cl", int'(cl), e_cl);
        chk("sph", int'(sph), e_sph);
        chk("spv", int'(spv), e_spv);
        chk("ckv", int'(ckv), e_ckv);
        chk("le", int'(le), e_le);
        chk("data", int'(data), e_data);
        chk("addr", int'(addr), e_addr);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        fd_cnt     += int'(frame_done);
        busy_cnt   += int'(busy);
        le_cnt     += int'(le);
        spv_lo_cnt += int'(!spv);
        sph_lo_cnt += int'(!sph);
        cl_hi_cnt  += int'(cl);
    endtask

    task automatic clear_counts();
        fd_cnt = 0; busy_cnt = 0; le_cnt = 0;
        spv_lo_cnt = 0; sph_lo_cnt = 0; cl_hi_cnt = 0;
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    endtask

    // run until the DUT returns to ready, bounded; abort pulsed at clock abort_at
    task automatic run_to_idle(input int abort_at, input string tag);
        int c;
        c = 0;
        while (c < 4000) begin
            c++;
            abort = (c == abort_at);
            step();
            abort = 1'b0;
            if (ready) break;
        end
        if (c >= 4000) chk({tag, "_timeout"}, 1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; phase_count = '0;
        for (int i = 0; i < 256; i++) mem[i] = DW'(i);
        clear_counts();

        tbl[0] = '{2,   0,   2, 384, 24, 64,  96};
        tbl[1] = '{5,   250, 2, 384, 24, 64,  96};
        tbl[2] = '{1,   0,   1, 192, 12, 32,  48};
        tbl[3] = '{3,   10,  1, 192, 12, 32,  48};
        tbl[4] = '{2,   384, 2, 384, 24, 64,  96};
        tbl[5] = '{3,   200, 2, 384, 24, 64,  96};
        tbl[6] = '{127, 500, 3, 576, 36, 96, 144};

        repeat (3) step();
        rst = 1'b0;
        step();

        // table-driven sequences (first row uses pix_data == addr)
        for (int r = 0; r < 7; r++) begin
            clear_counts();
            start = 1'b1; phase_count = PW'(tbl[r].pc);
            step();
            start = 1'b0;
            phase_count = PW'($urandom);
            run_to_idle(tbl[r].abort_at, "tbl");
            chk("tbl_frames", fd_cnt, tbl[r].frames);
            chk("tbl_busy_clks", busy_cnt, tbl[r].busy_clks);
            chk("tbl_le_clks", le_cnt, tbl[r].le_clks);
            chk("tbl_spv_low_clks", spv_lo_cnt, tbl[r].spv_lo_clks);
            chk("tbl_sph_low_clks", sph_lo_cnt, tbl[r].sph_lo_clks);
            step();
            randomize_mem();
        end

        // start with phase_count == 0 is ignored
        clear_counts();
        start = 1'b1; phase_count = '0;
        step();
        start = 1'b0;
        repeat (20) step();
        chk("pc0_cl_high", cl_hi_cnt, 0);
        chk("pc0_busy", busy_cnt, 0);

        // abort while idle must not carry into the next sequence
        abort = 1'b1;
        step();
        abort = 1'b0;
        clear_counts();
        start = 1'b1; phase_count = PW'(2);
        step();
        start = 1'b0;
        run_to_idle(0, "idle_abort");
        chk("idle_abort_frames", fd_cnt, 2);

        // reset mid-line at g=2, s=3, then a clean restart
        start = 1'b1; phase_count = PW'(2);
        step();
        start = 1'b0;
        repeat (80) step();   // tick 20 presents position g=2, s=3
        rst = 1'b1;
        step();
        chk("rst_ready", int'(ready), 1);
        chk("rst_sph", int'(sph), 1);
        chk("rst_addr", int'(addr), 0);
        rst = 1'b0;
        step();
        clear_counts();
        start = 1'b1; phase_count = PW'(1);
        step();
        start = 1'b0;
        run_to_idle(0, "after_rst");
        chk("after_rst_frames", fd_cnt, 1);
        chk("after_rst_busy_clks", busy_cnt, FCLK);

        // randomized stimulus against the model
        for (int it = 0; it < 25; it++) begin
            int c;
            randomize_mem();
            repeat ($urandom_range(0, 5)) begin
                abort = ($urandom_range(0, 3) == 0);
                step();
            end
            abort = 1'b0;
            start = 1'b1; phase_count = PW'($urandom_range(0, 4));
            step();
            c = 0;
            while (m_scan && c < 1500) begin
                c++;
                start = ($urandom_range(0, 49) == 0);
                phase_count = PW'($urandom_range(0, 6));
                abort = ($urandom_range(0, 299) == 0);
                rst = ($urandom_range(0, 1999) == 0);
                step();
            end
            start = 1'b0; abort = 1'b0; rst = 1'b0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
